im_stream: RTL and testbench
============================

IM_STREAM -- requirements
Module: im_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 64, pixels per line (>=2).
REQ-003 SHALL have parameter IMG_H, default 48, lines per image (>=2).
REQ-004 SHALL have parameter N_IMG, default 4, stored images (>=1, any integer).
REQ-005 SHALL derive localparams PIX_A_W=clog2(IMG_W*IMG_H) and IMG_A_W=max(1,clog2(N_IMG)).
REQ-006 Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  pixel write strobe
wr_img  in  IMG_A_W  target image index
wr_addr  in  PIX_A_W  pixel index, y*IMG_W+x
wr_data  in  PIX_W  pixel value
isel  in  IMG_A_W  image to stream
start  in  1  start request pulse
cont  in  1  1=continuous frames, 0=single frame
stop  in  1  stop request pulse
m_valid  out  1  output pixel valid
m_ready  in  1  sink accepts pixel
m_data  out  PIX_W  pixel value
m_sof  out  1  first pixel of frame
m_eol  out  1  last pixel of line
m_eof  out  1  last pixel of frame
busy  out  1  state not IDLE
done  out  1  one-cycle pulse after last pixel of final frame accepted
err  out  1  one-cycle pulse on rejected start

Function
REQ-007 Storage SHALL be an inferred synchronous RAM of N_IMG*IMG_W*IMG_H words, 1-cycle read latency, one write and one read port.
REQ-008 Write with wr_img>=N_IMG or wr_addr>=IMG_W*IMG_H SHALL be ignored.
REQ-009 Same-cycle write and read of one address SHALL return old data.
REQ-010 FSM states IDLE, RUN, LAST; IDLE->RUN on start with isel<N_IMG; RUN->LAST when stop seen or cont=0 at frame start; LAST->IDLE when m_eof pixel accepted.
REQ-011 start with isel>=N_IMG in IDLE SHALL pulse err and stay IDLE; start while busy SHALL be ignored without err.
REQ-012 isel and cont SHALL be sampled at start acceptance and at each frame boundary (continuous mode); mid-frame changes SHALL not affect the current frame.
REQ-013 Read address SHALL scan x 0..IMG_W-1 inner, y 0..IMG_H-1 outer, wrapping to 0,0 at frame end.
REQ-014 A pixel is transferred only when m_valid&&m_ready; while m_valid&&!m_ready, m_data and flags SHALL hold.
REQ-015 No pixel SHALL be dropped or duplicated under any m_ready pattern.
REQ-016 With m_ready held 1, first m_valid SHALL assert 2 cycles after start acceptance; throughput 1 pixel/cycle, including across frame boundaries in continuous mode.
REQ-017 m_sof on pixel (0,0), m_eol on x=IMG_W-1, m_eof on (IMG_W-1,IMG_H-1); all qualified by m_valid.
REQ-018 stop SHALL let the current frame complete; stop in IDLE ignored; stop and start in the same IDLE cycle: start wins.
REQ-019 done SHALL pulse the cycle after the final m_eof transfer; busy falls with it.
REQ-020 Writes SHALL remain accepted during streaming; pixels not yet read reflect new data.

Reset
REQ-021 On rst_n low: state IDLE, counters 0, buffer empty; m_valid, m_data, m_sof, m_eol, m_eof, busy, done, err all 0.
REQ-022 Reset mid-frame SHALL abort streaming immediately; RAM contents SHALL not be cleared.

Structure
REQ-023 Package im_stream_pkg SHALL hold the state enum and clog2-based width helper functions.
REQ-024 One sub-module im_stream_skid: 2-entry skid buffer holding {data,sof,eol,eof}, absorbing RAM latency under backpressure.

Verification (IMG_W=4, IMG_H=2, N_IMG=3, PIX_W=8)
REQ-025 Load image 1 with value=addr+16; start isel=1 cont=0, m_ready=1 -> 8 pixels 16..23 on consecutive cycles, eol on 19 and 23, eof on 23, done next cycle.
REQ-026 Same run with m_ready toggling 1,0,0,1 repeating -> identical 16..23 sequence, no loss/duplicate, data stable while stalled.
REQ-027 cont=1 isel=0, change isel to 2 mid-frame, assert stop in frame 2 -> frame 1 image 0, frame 2 image 2 fully, then IDLE with done.
REQ-028 start isel=3 -> err pulse, busy stays 0, no m_valid.
REQ-029 rst_n low after pixel 3 of a frame -> all outputs 0 immediately; new start streams from pixel (0,0) with preserved RAM data.
REQ-030 Write addr 6 of image 1 to 0xAA while streaming at pixel 2 -> pixel 6 output is 0xAA.

Source files
------------

// File: rtl/im_stream_pkg.sv
// Shared types, state codes and width helpers for the image streamer.
package im_stream_pkg;

    localparam int unsigned ST_W = 2;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_LAST = 2'd2;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pix_flags_t;

    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (longint unsigned n = 1; n < longint'(v); n = n * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Address width that never collapses to zero bits.
    function automatic int unsigned width_f(input int unsigned v);
        return (clog2_f(v) < 1) ? 1 : clog2_f(v);
    endfunction

endpackage

// File: rtl/im_stream_skid.sv
// Two-entry skid buffer; entry 0 is the registered output stage.
module im_stream_skid
    import im_stream_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_sof,
    input  logic             in_eol,
    input  logic             in_eof,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof,
    output logic [1:0]       count_c
);

    logic             v1_q;
    logic [PIX_W-1:0] d1_q;
    pix_flags_t       f0_q;
    pix_flags_t       f1_q;
    pix_flags_t       in_flags_c;
    logic             pop_c;

    assign in_flags_c = '{sof: in_sof, eol: in_eol, eof: in_eof};
    assign pop_c      = out_valid && out_ready;
    assign count_c    = 2'(out_valid) + 2'(v1_q);
    assign out_sof    = f0_q.sof;
    assign out_eol    = f0_q.eol;
    assign out_eof    = f0_q.eof;

    // The producer only pushes when a slot is guaranteed free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            f0_q      <= '0;
            v1_q      <= 1'b0;
            d1_q      <= '0;
            f1_q      <= '0;
        end else if (!out_valid || pop_c) begin
            if (v1_q) begin
                out_valid <= 1'b1;
                out_data  <= d1_q;
                f0_q      <= f1_q;
                v1_q      <= in_valid;
                if (in_valid) begin
                    d1_q <= in_data;
                    f1_q <= in_flags_c;
                end
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_data <= in_data;
                    f0_q     <= in_flags_c;
                end
            end
        end else if (in_valid) begin
            v1_q <= 1'b1;
            d1_q <= in_data;
            f1_q <= in_flags_c;
        end
    end

endmodule

// File: rtl/im_stream.sv
// Multi-image frame buffer streamed out as raster-order pixels with
// sof/eol/eof markers and ready/valid backpressure.
module im_stream
    import im_stream_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 48,
    parameter int unsigned N_IMG = 4,
    localparam int unsigned PIX_A_W = clog2_f(IMG_W * IMG_H),
    localparam int unsigned IMG_A_W = width_f(N_IMG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [IMG_A_W-1:0] wr_img,
    input  logic [PIX_A_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]   wr_data,
    input  logic [IMG_A_W-1:0] isel,
    input  logic               start,
    input  logic               cont,
    input  logic               stop,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [PIX_W-1:0]   m_data,
    output logic               m_sof,
    output logic               m_eol,
    output logic               m_eof,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned NPIX    = IMG_W * IMG_H;
    localparam int unsigned DEPTH   = N_IMG * NPIX;
    localparam int unsigned RAM_A_W = width_f(DEPTH);
    localparam int unsigned X_W     = width_f(IMG_W);

    logic [PIX_W-1:0]   mem [DEPTH];
    logic [PIX_W-1:0]   ram_q;
    logic [RAM_A_W-1:0] wr_idx_c;
    logic [RAM_A_W-1:0] rd_idx_c;
    logic               wr_ok_c;
    logic               rd_en_c;

    state_t             state_q;
    state_t             state_d;
    logic               busy_d;
    logic               done_d;
    logic               err_d;

    logic [IMG_A_W-1:0] cur_img_q;
    logic               cur_cont_q;
    logic [PIX_A_W-1:0] pix_q;
    logic [X_W-1:0]     x_q;
    logic               issue_end_q;
    logic               rd_vld_q;
    pix_flags_t         rd_flags_q;
    pix_flags_t         issue_flags_c;

    logic [1:0]         skid_cnt_c;
    logic               isel_ok_c;
    logic               start_ok_c;
    logic               pop_c;
    logic               frame_end_c;
    logic               line_end_c;
    logic               more_frames_c;
    logic               final_xfer_c;

    assign isel_ok_c     = 32'(isel) < N_IMG;
    assign start_ok_c    = (state_q == ST_IDLE) && start && isel_ok_c;
    assign pop_c         = m_valid && m_ready;
    assign frame_end_c   = 32'(pix_q) == NPIX - 1;
    assign line_end_c    = 32'(x_q) == IMG_W - 1;
    assign more_frames_c = (state_q == ST_RUN) && cur_cont_q && !stop;
    assign final_xfer_c  = issue_end_q && pop_c && m_eof;

    assign issue_flags_c = '{sof: (pix_q == '0), eol: line_end_c, eof: frame_end_c};

    // Issue a read only if the skid buffer can absorb it after this cycle's pop.
    assign rd_en_c = (state_q != ST_IDLE) && !issue_end_q &&
                     ((3'(skid_cnt_c) + 3'(rd_vld_q)) <= (3'd1 + 3'(pop_c)));

    assign wr_ok_c  = wr_en && (32'(wr_img) < N_IMG) && (32'(wr_addr) < NPIX);
    assign wr_idx_c = RAM_A_W'(32'(wr_img) * NPIX + 32'(wr_addr));
    assign rd_idx_c = RAM_A_W'(32'(cur_img_q) * NPIX + 32'(pix_q));

    // Simple dual-port RAM, read-before-write on address collision.
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wr_idx_c] <= wr_data;
        end
        if (rd_en_c) begin
            ram_q <= mem[rd_idx_c];
        end
    end

    // Raster scan counters; image and mode are re-sampled only at frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_img_q   <= '0;
            cur_cont_q  <= 1'b0;
            pix_q       <= '0;
            x_q         <= '0;
            issue_end_q <= 1'b0;
        end else if (start_ok_c) begin
            cur_img_q   <= isel;
            cur_cont_q  <= cont;
            pix_q       <= '0;
            x_q         <= '0;
            issue_end_q <= 1'b0;
        end else if (rd_en_c) begin
            if (frame_end_c) begin
                pix_q <= '0;
                x_q   <= '0;
                if (more_frames_c) begin
                    cur_img_q  <= isel_ok_c ? isel : cur_img_q;
                    cur_cont_q <= cont;
                end else begin
                    issue_end_q <= 1'b1;
                end
            end else begin
                pix_q <= pix_q + PIX_A_W'(1);
                x_q   <= line_end_c ? '0 : x_q + X_W'(1);
            end
        end
    end

    // Flags travel alongside the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q   <= 1'b0;
            rd_flags_q <= '0;
        end else begin
            rd_vld_q <= rd_en_c;
            if (rd_en_c) begin
                rd_flags_q <= issue_flags_c;
            end
        end
    end

    im_stream_skid #(
        .PIX_W (PIX_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_vld_q),
        .in_data   (ram_q),
        .in_sof    (rd_flags_q.sof),
        .in_eol    (rd_flags_q.eol),
        .in_eof    (rd_flags_q.eof),
        .out_ready (m_ready),
        .out_valid (m_valid),
        .out_data  (m_data),
        .out_sof   (m_sof),
        .out_eol   (m_eol),
        .out_eof   (m_eof),
        .count_c   (skid_cnt_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    // LAST means no further frame will be issued after the current one.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (isel_ok_c) begin
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (final_xfer_c) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (stop || !cur_cont_q) begin
                    state_d = ST_LAST;
                end
            end
            ST_LAST: begin
                if (final_xfer_c) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_im_stream.sv
// Self-checking bench for im_stream: scoreboarded pixel streams against an
// image-memory model, with directed, table-driven and randomized runs.
module tb_im_stream;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 2;
    localparam int unsigned N_IMG = 3;
    localparam int NPIX = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_img = '0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [1:0] isel = '0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       stop = 1'b0;
    logic       m_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_sof, m_eol, m_eof, busy, done, err;

    im_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .N_IMG(N_IMG)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_img(wr_img), .wr_addr(wr_addr),
        .wr_data(wr_data), .isel(isel), .start(start), .cont(cont), .stop(stop),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
        .m_eol(m_eol), .m_eof(m_eof), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       sof, eol, eof;
        int         cyc;
    } xfer_t;

    typedef struct {
        logic [1:0] isel;
        logic       exp_err;
        logic       exp_busy;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         ready_mode = 0;
    xfer_t      obs[$];
    xfer_t      exp_q[$];
    int         done_cyc[$];
    int         err_cyc[$];
    logic [7:0] model [N_IMG][NPIX];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pk(input xfer_t x);
        return 32'({x.d, x.sof, x.eol, x.eof});
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Sink readiness pattern: always, 1-0-0-1 repeating, or random.
    initial begin
        int k;
        k = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: m_ready = (k % 4 == 0) || (k % 4 == 3);
                2: m_ready = ($urandom % 4) != 0;
                default: m_ready = 1'b1;
            endcase
            k++;
        end
    end

    // Monitor: collects transfers and pulses, checks hold-while-stalled.
    initial begin
        logic        stall_q;
        logic [11:0] prev;
        xfer_t       x;
        stall_q = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) check("stall_hold", 32'({m_valid, m_data, m_sof, m_eol, m_eof}), 32'(prev));
                if (m_valid && m_ready) begin
                    x.d = m_data; x.sof = m_sof; x.eol = m_eol; x.eof = m_eof; x.cyc = cyc;
                    obs.push_back(x);
                end
                if (done) begin
                    done_cyc.push_back(cyc);
                    check("busy_falls_with_done", 32'(busy), 0);
                end
                if (err) err_cyc.push_back(cyc);
                stall_q = m_valid && !m_ready;
                prev = {m_valid, m_data, m_sof, m_eol, m_eof};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int img, input int addr, input int data);
        wr_en = 1'b1; wr_img = 2'(img); wr_addr = 3'(addr); wr_data = 8'(data);
        tick();
        wr_en = 1'b0;
        if (img < int'(N_IMG) && addr < NPIX) model[img][addr] = 8'(data);
    endtask

    task automatic add_frame(input int img);
        for (int p = 0; p < NPIX; p++) begin
            xfer_t e;
            e.d = model[img][p];
            e.sof = (p == 0);
            e.eol = (p % int'(IMG_W)) == int'(IMG_W) - 1;
            e.eof = (p == NPIX - 1);
            e.cyc = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic compare_stream(input string name);
        check({name, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            check($sformatf("%s_pix%0d", name, i), pk(obs[i]), pk(exp_q[i]));
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n0;
        n0 = done_cyc.size();
        for (int i = 0; i < budget && done_cyc.size() == n0; i++) tick();
        check({name, "_done_seen"}, 32'(done_cyc.size() > n0), 1);
        tick();
    endtask

    task automatic wait_obs(input string name, input int n, input int budget);
        for (int i = 0; i < budget && obs.size() < n; i++) tick();
        check({name, "_reached"}, 32'(obs.size() >= n), 1);
    endtask

    task automatic run_frame(input string name, input int img);
        obs.delete(); exp_q.delete();
        add_frame(img);
        isel = 2'(img); cont = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(name, 400);
        compare_stream(name);
    endtask

    initial begin
        vec_t tbl[5];
        int   c0;
        tbl[0] = '{isel: 2'd3, exp_err: 1'b1, exp_busy: 1'b0};
        tbl[1] = '{isel: 2'd0, exp_err: 1'b0, exp_busy: 1'b1};
        tbl[2] = '{isel: 2'd2, exp_err: 1'b0, exp_busy: 1'b1};
        tbl[3] = '{isel: 2'd3, exp_err: 1'b1, exp_busy: 1'b0};
        tbl[4] = '{isel: 2'd1, exp_err: 1'b0, exp_busy: 1'b1};

        #2;
        check("reset_outputs", 32'({m_valid, m_data, m_sof, m_eol, m_eof, busy, done, err}), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        for (int p = 0; p < NPIX; p++) begin
            wr(0, p, 8'h40 + p);
            wr(1, p, 16 + p);
            wr(2, p, 8'h80 + p);
        end
        wr(3, 0, 8'hFF);

        // Single frame, full throughput, exact latency.
        obs.delete(); exp_q.delete(); done_cyc.delete();
        add_frame(1);
        c0 = cyc;
        isel = 2'd1; cont = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("single", 100);
        compare_stream("single");
        for (int i = 0; i < obs.size(); i++) check($sformatf("single_cyc%0d", i), obs[i].cyc, c0 + 3 + i);
        check("single_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, c0 + 11);
        check("single_idle_busy", 32'(busy), 0);

        ready_mode = 1;
        run_frame("toggle_ready", 1);
        ready_mode = 0;

        // Table: start acceptance / rejection.
        for (int t = 0; t < 5; t++) begin
            obs.delete(); exp_q.delete(); err_cyc.delete();
            isel = tbl[t].isel; cont = 1'b0; start = 1'b1;
            tick();
            start = 1'b0;
            check($sformatf("tbl%0d_err", t), 32'(err), 32'(tbl[t].exp_err));
            check($sformatf("tbl%0d_busy", t), 32'(busy), 32'(tbl[t].exp_busy));
            tick();
            check($sformatf("tbl%0d_err_pulse", t), 32'(err), 0);
            if (tbl[t].exp_err) begin
                repeat (4) tick();
                check($sformatf("tbl%0d_no_valid", t), obs.size(), 0);
                check($sformatf("tbl%0d_idle", t), 32'(busy), 0);
            end else begin
                add_frame(int'(tbl[t].isel));
                wait_done($sformatf("tbl%0d", t), 200);
                compare_stream($sformatf("tbl%0d", t));
            end
        end

        // Stop alone in IDLE is ignored; stop with start lets start win.
        obs.delete(); exp_q.delete();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
        check("idle_stop_busy", 32'(busy), 0);
        check("idle_stop_no_valid", obs.size(), 0);
        add_frame(0);
        isel = 2'd0; cont = 1'b0; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        wait_done("start_stop", 200);
        compare_stream("start_stop");

        // Continuous mode, image switch mid-frame, stop in frame 2.
        obs.delete(); exp_q.delete(); err_cyc.delete();
        add_frame(0); add_frame(2);
        isel = 2'd0; cont = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_obs("cont_f1", 2, 50);
        isel = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        wait_obs("cont_f2", NPIX + 2, 50);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("cont", 200);
        compare_stream("cont");
        check("cont_no_err", err_cyc.size(), 0);
        cont = 1'b0;

        // Reset mid-frame aborts; RAM survives.
        obs.delete();
        isel = 2'd1; cont = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_obs("rst_mid", 3, 50);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({m_valid, m_data, m_sof, m_eol, m_eof, busy, done, err}), 0);
        tick(); tick();
        rst_n = 1'b1;
        cont = 1'b0;
        tick();
        run_frame("after_rst", 1);

        // Write to a not-yet-read pixel while streaming.
        obs.delete(); exp_q.delete();
        isel = 2'd1; cont = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_obs("live_wr", 2, 50);
        wr(1, 6, 8'hAA);
        add_frame(1);
        wait_done("live_wr", 200);
        compare_stream("live_wr");
        check("live_wr_pix6", (obs.size() > 6) ? int'(obs[6].d) : -1, 8'hAA);

        // Randomized contents, ignored writes and sink backpressure.
        ready_mode = 2;
        for (int r = 0; r < 6; r++) begin
            repeat (6) wr($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 255));
            run_frame($sformatf("rnd%0d", r), $urandom_range(0, 2));
        end
        ready_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
